// File: rtl/encoder_counter_bank.sv
// rtl/encoder_counter_bank.sv - quadrature encoder counter bank on a multiplexed 8-bit bus
// Optional feature macro: COUNTER_WRAP_FLAG_EN (sticky per-channel wrap flags readable at 0x83).
module encoder_counter_bank #(
    parameter int         CHANNELS     = 4,
    parameter int         COUNT_WIDTH  = 16,
    parameter int         FILTER_DEPTH = 3,
    parameter logic [7:0] MODE_RESET   = 8'h0C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] q,
    input  logic                  ale,
    input  logic                  rd,
    input  logic                  wr,
    inout  wire  [7:0]            ad
);

    localparam int NBYTES = COUNT_WIDTH / 8;
    localparam int FW     = $clog2(FILTER_DEPTH);

    // Encoder input path
    logic [2*CHANNELS-1:0] q_s1_q, q_s2_q;
    logic [2*CHANNELS-1:0] filt_q, filt_d;
    logic [FW-1:0]         fcnt_q [2*CHANNELS];
    logic [FW-1:0]         fcnt_d [2*CHANNELS];
    logic [2*CHANNELS-1:0] dec_q;

    // Counters and registers
    logic [COUNT_WIDTH-1:0] count_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] count_d [CHANNELS];
    logic [COUNT_WIDTH-1:0] snap_q, snap_d;
    logic [CHANNELS-1:0]    mode_q, mode_d;
    logic [CHANNELS-1:0]    clr;
    logic [CHANNELS-1:0]    up, dn;
    logic [3:0]             step_code [CHANNELS];

    // Bus path
    logic       ale_s1_q, ale_s2_q, ale_s3_q;
    logic       wr_s1_q, wr_s2_q, wr_s3_q;
    logic [7:0] ad_s1_q, ad_s2_q, ad_s3_q;
    logic [7:0] addr_q, addr_d;
    logic [7:0] latch_q, latch_d;
    logic       ale_fall, wr_rise;

`ifdef COUNTER_WRAP_FLAG_EN
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] wflag_q, wflag_d;
    logic                wflag_clr;
`endif

    // Read data is driven straight from the rd pin so the bus sees data without sync delay
    assign ad = rd ? 8'bz : latch_q;

    assign ale_fall = ale_s3_q & ~ale_s2_q;
    assign wr_rise  = ~wr_s3_q & wr_s2_q;

    // Two-flop synchronisers for encoder pins and bus signals (ad kept aligned with strobes)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_s1_q   <= '0;
            q_s2_q   <= '0;
            ale_s1_q <= 1'b0;
            ale_s2_q <= 1'b0;
            ale_s3_q <= 1'b0;
            wr_s1_q  <= 1'b1;
            wr_s2_q  <= 1'b1;
            wr_s3_q  <= 1'b1;
            ad_s1_q  <= '0;
            ad_s2_q  <= '0;
            ad_s3_q  <= '0;
        end else begin
            q_s1_q   <= q;
            q_s2_q   <= q_s1_q;
            ale_s1_q <= ale;
            ale_s2_q <= ale_s1_q;
            ale_s3_q <= ale_s2_q;
            wr_s1_q  <= wr;
            wr_s2_q  <= wr_s1_q;
            wr_s3_q  <= wr_s2_q;
            ad_s1_q  <= ad;
            ad_s2_q  <= ad_s1_q;
            ad_s3_q  <= ad_s2_q;
        end
    end

    // Per-bit noise filter: accept a new level after FILTER_DEPTH consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2*CHANNELS; i++) begin
            fcnt_d[i] = '0;
            if (q_s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_DEPTH - 1)) begin
                    filt_d[i] = q_s2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    // Gray decoder and counter next-state; clear has priority over a step
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            step_code[c] = {dec_q[2*c +: 2], filt_q[2*c +: 2]};
            up[c] = 1'b0;
            dn[c] = 1'b0;
            case (step_code[c])
                4'b0001, 4'b0111, 4'b1110, 4'b1000: up[c] = mode_q[c] | (step_code[c][1:0] == 2'b00);
                4'b0010, 4'b1011, 4'b1101, 4'b0100: dn[c] = mode_q[c] | (step_code[c][1:0] == 2'b10);
                default: ;
            endcase
            count_d[c] = count_q[c];
            if (clr[c]) begin
                count_d[c] = '0;
            end else if (up[c]) begin
                count_d[c] = count_q[c] + COUNT_WIDTH'(1);
            end else if (dn[c]) begin
                count_d[c] = count_q[c] - COUNT_WIDTH'(1);
            end
`ifdef COUNTER_WRAP_FLAG_EN
            wrap[c] = (up[c] && (&count_q[c])) || (dn[c] && (count_q[c] == '0));
`endif
        end
    end

    // Address phase loads the read latch; write phase updates mode or clears counters
    always_comb begin
        addr_d  = addr_q;
        latch_d = latch_q;
        snap_d  = snap_q;
        mode_d  = mode_q;
        clr     = '0;
`ifdef COUNTER_WRAP_FLAG_EN
        wflag_clr = 1'b0;
`endif
        if (ale_fall) begin
            addr_d  = ad_s3_q;
            latch_d = 8'h00;
            if (!ad_s3_q[7]) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ad_s3_q[4:2] == 3'(c)) begin
                        if (ad_s3_q[1:0] == 2'b00) begin
                            latch_d = count_q[c][7:0];
                            snap_d  = count_q[c];
                        end else begin
                            for (int k = 1; k < NBYTES; k++) begin
                                if (ad_s3_q[1:0] == 2'(k)) begin
                                    latch_d = snap_q[8*k +: 8];
                                end
                            end
                        end
                    end
                end
            end else begin
                case (ad_s3_q)
                    8'h80: latch_d = 8'(mode_q);
                    8'h82: latch_d = {4'(CHANNELS), 2'(NBYTES - 1), 2'b01};
`ifdef COUNTER_WRAP_FLAG_EN
                    8'h83: begin
                        latch_d   = 8'(wflag_q);
                        wflag_clr = 1'b1;
                    end
`endif
                    default: latch_d = 8'h00;
                endcase
            end
        end
        if (wr_rise) begin
            if (addr_q == 8'h80) begin
                mode_d = ad_s3_q[CHANNELS-1:0];
            end else if (addr_q == 8'h81) begin
                clr = ad_s3_q[CHANNELS-1:0];
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q  <= '0;
            dec_q   <= '0;
            snap_q  <= '0;
            mode_q  <= MODE_RESET[CHANNELS-1:0];
            addr_q  <= '0;
            latch_q <= '0;
            for (int i = 0; i < 2*CHANNELS; i++) begin
                fcnt_q[i] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c] <= '0;
            end
        end else begin
            filt_q  <= filt_d;
            dec_q   <= filt_q;
            snap_q  <= snap_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            latch_q <= latch_d;
            for (int i = 0; i < 2*CHANNELS; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c] <= count_d[c];
            end
        end
    end

`ifdef COUNTER_WRAP_FLAG_EN
    // Sticky wrap flags; a wrap coinciding with the read-clear re-sets the flag
    always_comb begin
        wflag_d = (wflag_q & ~{CHANNELS{wflag_clr}}) | wrap;
    end

    // Wrap flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wflag_q <= '0;
        end else begin
            wflag_q <= wflag_d;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_counter_bank.sv
// tb/tb_encoder_counter_bank.sv - self-checking bench for encoder_counter_bank
module tb_encoder_counter_bank;

    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] q_in = 8'h00;
    logic       ale = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b1;
    logic [7:0] ad_drv = 8'h00;
    logic       ad_oe = 1'b0;
    wire  [7:0] ad;

    assign ad = ad_oe ? ad_drv : 8'bz;

    encoder_counter_bank #(
        .CHANNELS(CH), .COUNT_WIDTH(16), .FILTER_DEPTH(3), .MODE_RESET(8'h0C)
    ) dut (
        .clk(clk), .rst(rst), .q(q_in), .ale(ale), .rd(rd), .wr(wr), .ad(ad)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] m_cnt [CH];
    logic [1:0]  m_st  [CH];
    logic [7:0]  m_mode;
    logic [3:0]  m_wrap;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic addr_phase(input logic [7:0] a);
        @(negedge clk);
        ad_oe = 1'b1; ad_drv = a; ale = 1'b1;
        repeat (4) @(negedge clk);
        ale = 1'b0; ad_oe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] e, input string name);
        logic [7:0] got;
        logic [7:0] want;
        exp_q.push_back(e);
        addr_phase(a);
        rd = 1'b0;
        repeat (3) @(negedge clk);
        got = ad;
        rd = 1'b1;
        @(negedge clk);
        want = exp_q.pop_front();
        check(name, {24'h0, got}, {24'h0, want});
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr_phase(a);
        ad_oe = 1'b1; ad_drv = d; wr = 1'b0;
        repeat (4) @(negedge clk);
        wr = 1'b1;
        repeat (4) @(negedge clk);
        ad_oe = 1'b0;
    endtask

    // One Gray step on channel c; the model decides whether it counts
    task automatic step(input int c, input bit fwd);
        logic [1:0] s;
        logic [1:0] n;
        s = m_st[c];
        n = fwd ? {s[0], ~s[1]} : {~s[0], s[1]};
        if (fwd && (m_mode[c] || n == 2'b00)) begin
            if (m_cnt[c] == 16'hFFFF) m_wrap[c] = 1'b1;
            m_cnt[c] = m_cnt[c] + 16'd1;
        end else if (!fwd && (m_mode[c] || n == 2'b10)) begin
            if (m_cnt[c] == 16'h0000) m_wrap[c] = 1'b1;
            m_cnt[c] = m_cnt[c] - 16'd1;
        end
        m_st[c] = n;
        q_in[2*c +: 2] = n;
        repeat (7) @(negedge clk);
    endtask

    function automatic logic [7:0] wrap_exp();
`ifdef COUNTER_WRAP_FLAG_EN
        return {4'h0, m_wrap};
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = '0;
            m_st[c]  = '0;
        end
        m_mode = 8'h0C;
        m_wrap = '0;

        // In reset with rd low the bus is driven with zero
        repeat (3) @(negedge clk);
        check("reset_ad", {24'h0, ad}, 32'h0);
        rd = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset-state register map
        vecs[0]  = '{8'h00, 8'h00};
        vecs[1]  = '{8'h01, 8'h00};
        vecs[2]  = '{8'h04, 8'h00};
        vecs[3]  = '{8'h0B, 8'h00};
        vecs[4]  = '{8'h0E, 8'h00};
        vecs[5]  = '{8'h10, 8'h00};
        vecs[6]  = '{8'h80, 8'h0C};
        vecs[7]  = '{8'h81, 8'h00};
        vecs[8]  = '{8'h82, 8'h45};
        vecs[9]  = '{8'h83, 8'h00};
        vecs[10] = '{8'h84, 8'h00};
        vecs[11] = '{8'hFF, 8'h00};
        for (int i = 0; i < 12; i++) begin
            bus_read(vecs[i].addr, vecs[i].exp, $sformatf("reset_map_%02h", vecs[i].addr));
        end

        // Full mode ch2: 8 forward steps
        for (int i = 0; i < 8; i++) step(2, 1'b1);
        bus_read(8'h08, 8'h08, "ch2_full_b0");
        bus_read(8'h09, 8'h00, "ch2_full_b1");

        // Div4 ch0: forward, reverse, invalid jump
        for (int i = 0; i < 8; i++) step(0, 1'b1);
        bus_read(8'h00, 8'h02, "ch0_div4_fwd");
        for (int i = 0; i < 4; i++) step(0, 1'b0);
        bus_read(8'h00, 8'h01, "ch0_div4_rev");
        q_in[1:0] = 2'b11;
        repeat (8) @(negedge clk);
        q_in[1:0] = 2'b00;
        repeat (8) @(negedge clk);
        bus_read(8'h00, m_cnt[0][7:0], "ch0_glitch");

        // Filter: short pulse rejected, held level counts on the 6th edge
        q_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        q_in[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("filter_pulse", {16'h0, dut.count_q[0]}, 32'h1);
        q_in[1] = 1'b1;
        repeat (5) @(negedge clk);
        check("filter_edge5", {16'h0, dut.count_q[0]}, 32'h1);
        @(negedge clk);
        check("filter_edge6", {16'h0, dut.count_q[0]}, 32'h0);
        m_st[0] = 2'b10;
        m_cnt[0] = 16'h0000;
        repeat (3) @(negedge clk);
        step(0, 1'b1);
        bus_read(8'h00, m_cnt[0][7:0], "filter_return");

        // Mode write and readback
        bus_write(8'h80, 8'h0F);
        m_mode = 8'h0F;
        bus_read(8'h80, 8'h0F, "mode_rb");

        // Atomic snapshot on ch1
        for (int i = 0; i < 255; i++) step(1, 1'b1);
        bus_read(8'h04, 8'hFF, "atomic_b0");
        step(1, 1'b1);
        bus_read(8'h05, 8'h00, "atomic_b1_snap");
        bus_read(8'h04, 8'h00, "atomic_new_b0");
        bus_read(8'h05, 8'h01, "atomic_new_b1");

        // Wrap in both directions on ch0
        bus_write(8'h81, 8'h01);
        m_cnt[0] = 16'h0000;
        step(0, 1'b0);
        bus_read(8'h00, 8'hFF, "wrap_dn_b0");
        bus_read(8'h01, 8'hFF, "wrap_dn_b1");
        bus_read(8'h83, wrap_exp(), "wrap_flag_dn");
        m_wrap = '0;
        bus_read(8'h83, 8'h00, "wrap_flag_clr1");
        step(0, 1'b1);
        bus_read(8'h00, 8'h00, "wrap_up_b0");
        bus_read(8'h01, 8'h00, "wrap_up_b1");
        bus_read(8'h83, wrap_exp(), "wrap_flag_up");
        m_wrap = '0;
        bus_read(8'h83, 8'h00, "wrap_flag_clr2");

        // Clear ch0 and ch2 while ch3 keeps stepping
        step(0, 1'b1);
        step(0, 1'b1);
        fork
            bus_write(8'h81, 8'h05);
            for (int i = 0; i < 5; i++) step(3, 1'b1);
        join
        m_cnt[0] = '0;
        m_cnt[2] = '0;
        bus_read(8'h00, 8'h00, "clr_ch0");
        bus_read(8'h08, 8'h00, "clr_ch2");
        bus_read(8'h04, m_cnt[1][7:0], "clr_keep_ch1");
        bus_read(8'h0C, m_cnt[3][7:0], "clr_keep_ch3");
        step(0, 1'b1);
        bus_read(8'h00, m_cnt[0][7:0], "post_clr_ch0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
